// File: rtl/accum_window_ctrl_pkg.sv
// Shared definitions for the accumulator window controller: FSM state encodings
// and the constant clog2 helper reused by other accumulator blocks.
package accum_window_ctrl_pkg;

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_ACC  = 2'd1,
        S_DUMP = 2'd2
    } state_e;

    // Smallest n with 2**n >= value; usable in parameter and localparam expressions.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/accum_window_ctrl_if.sv
// Bundle of the sample input, accumulator-side and result-output signals of the
// window controller; the controller is the slave, its environment the master.
interface accum_window_ctrl_if
    import accum_window_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int WIN   = 8
);
    localparam int CW = clog2(WIN + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] din;
    logic             flush;

    logic [WIDTH-1:0] acc_d;
    logic             acc_clr;
    logic [WIDTH-1:0] acc_q;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    out_cnt;
    logic             out_ovf;

    modport slave (
        input  in_valid, din, flush, acc_q, out_ready,
        output in_ready, acc_d, acc_clr, out_valid, out_data, out_cnt, out_ovf
    );

    modport master (
        output in_valid, din, flush, acc_q, out_ready,
        input  in_ready, acc_d, acc_clr, out_valid, out_data, out_cnt, out_ovf
    );

endinterface

// File: rtl/accum_window_ctrl.sv
// Window controller for a sibling unsigned accumulator: feeds and clears it, counts
// samples per window and buffers each window sum with a sticky wrap flag.
module accum_window_ctrl
    import accum_window_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int WIN   = 8
)
(
    input  logic              clk,
    input  logic              rst,
    accum_window_ctrl_if.slave bus
);

    localparam int            CW      = clog2(WIN + 1);
    localparam logic [CW-1:0] WIN_CNT = CW'(WIN);

    state_e           r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_ovf;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [CW-1:0]    r_out_cnt;
    logic             r_out_ovf;

    logic             w_accept;
    logic [WIDTH:0]   w_sum;
    logic             w_carry;
    logic [CW-1:0]    w_cnt_next;
    logic             w_ovf_next;
    logic             w_close;
    logic             w_slot_free;
    logic             w_capture;

    assign w_accept    = (r_state == S_ACC) && bus.in_valid;
    assign w_sum       = {1'b0, bus.acc_q} + {1'b0, bus.din};
    assign w_carry     = |(w_sum >> WIDTH);
    assign w_cnt_next  = r_cnt + {{(CW-1){1'b0}}, w_accept};
    assign w_ovf_next  = r_ovf | (w_accept & w_carry);
    // A sample accepted alongside flush belongs to the window being closed.
    assign w_close     = (w_accept && (w_cnt_next == WIN_CNT)) ||
                         (bus.flush && (w_cnt_next != '0));
    assign w_slot_free = !r_out_valid || bus.out_ready;
    assign w_capture   = (r_state == S_DUMP) && w_slot_free;

    assign bus.in_ready  = (r_state == S_ACC);
    assign bus.acc_clr   = (r_state == S_INIT) || w_capture;
    assign bus.acc_d     = w_accept ? bus.din : '0;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_cnt   = r_out_cnt;
    assign bus.out_ovf   = r_out_ovf;

    // NOTE: non-blocking assignments so every register samples pre-edge values;
    // the later r_out_valid write in DUMP overrides the transfer clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_INIT;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_cnt   <= '0;
            r_out_ovf   <= 1'b0;
        end else begin
            if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
            case (r_state)
                S_INIT: begin
                    r_state <= S_ACC;
                end
                S_ACC: begin
                    r_cnt <= w_cnt_next;
                    r_ovf <= w_ovf_next;
                    if (w_close) begin
                        r_state <= S_DUMP;
                    end
                end
                S_DUMP: begin
                    // acc_q holds the complete window sum here; acc_clr fires with the capture.
                    if (w_slot_free) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= bus.acc_q;
                        r_out_cnt   <= r_cnt;
                        r_out_ovf   <= r_ovf;
                        r_cnt       <= '0;
                        r_ovf       <= 1'b0;
                        r_state     <= S_ACC;
                    end
                end
                default: begin
                    r_state <= S_INIT;
                end
            endcase
        end
    end

    a_out_stable: assert property (@(posedge clk) disable iff (!rst)
        (r_out_valid && !bus.out_ready) |=>
            (r_out_valid && $stable(r_out_data) && $stable(r_out_cnt) && $stable(r_out_ovf)));

    a_ready_clr_exclusive: assert property (@(posedge clk) disable iff (!rst)
        !(bus.in_ready && bus.acc_clr));

endmodule

// File: tb/tb_accum_window_ctrl.sv
// Self-checking bench for accum_window_ctrl with a behavioural sibling accumulator,
// a window-level reference model checked every cycle, and directed literal checks.
module tb_accum_window_ctrl;
    import accum_window_ctrl_pkg::*;

    localparam int WIDTH = 4;
    localparam int WIN   = 4;
    localparam int MOD   = 1 << WIDTH;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    accum_window_ctrl_if #(.WIDTH(WIDTH), .WIN(WIN)) bus ();

    accum_window_ctrl #(.WIDTH(WIDTH), .WIN(WIN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Sibling accumulator as the parent would instantiate it.
    logic [WIDTH-1:0] r_acc;
    always @(posedge clk) begin
        if (bus.acc_clr) r_acc <= '0;
        else             r_acc <= r_acc + bus.acc_d;
    end
    assign bus.acc_q = r_acc;

    // Reference model: window contents as a list of samples, one closed window
    // awaiting capture, and the presented result.
    bit m_clearing;
    bit m_closing;
    int m_win[$];
    int m_pend_data, m_pend_cnt;
    bit m_pend_ovf;
    bit m_out_valid;
    int m_out_data, m_out_cnt;
    bit m_out_ovf;
    bit m_dut_accept;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        m_clearing  = 1'b1;
        m_closing   = 1'b0;
        m_win.delete();
        m_out_valid = 1'b0;
        m_out_data  = 0;
        m_out_cnt   = 0;
        m_out_ovf   = 1'b0;
    endtask

    task automatic close_window();
        int total;
        total = 0;
        foreach (m_win[i]) total += m_win[i];
        m_pend_data = total % MOD;
        m_pend_cnt  = m_win.size();
        m_pend_ovf  = (total >= MOD);
        m_win.delete();
        m_closing   = 1'b1;
    endtask

    // One clock cycle: called at a falling edge with inputs already applied.
    task automatic cycle();
        bit slot_free, exp_ready, exp_clr, accept;
        #1;
        m_dut_accept = bus.in_ready && bus.in_valid;
        if (!rst) begin
            check("rst_in_ready", bus.in_ready, 0);
            check("rst_acc_clr", bus.acc_clr, 1);
            check("rst_acc_d", bus.acc_d, 0);
            check("rst_out_valid", bus.out_valid, 0);
            check("rst_out_data", bus.out_data, 0);
            check("rst_out_cnt", bus.out_cnt, 0);
            check("rst_out_ovf", bus.out_ovf, 0);
        end else begin
            slot_free = !m_out_valid || bus.out_ready;
            exp_ready = !m_clearing && !m_closing;
            exp_clr   = m_clearing || (m_closing && slot_free);
            accept    = exp_ready && bus.in_valid;
            check("in_ready", bus.in_ready, exp_ready);
            check("acc_clr", bus.acc_clr, exp_clr);
            check("acc_d", bus.acc_d, accept ? 32'(bus.din) : 32'd0);
            check("out_valid", bus.out_valid, m_out_valid);
            if (m_out_valid) begin
                check("out_data", bus.out_data, m_out_data);
                check("out_cnt", bus.out_cnt, m_out_cnt);
                check("out_ovf", bus.out_ovf, m_out_ovf);
            end
            if (m_out_valid && bus.out_ready) m_out_valid = 1'b0;
            if (m_clearing) begin
                m_clearing = 1'b0;
            end else if (m_closing) begin
                if (slot_free) begin
                    m_out_valid = 1'b1;
                    m_out_data  = m_pend_data;
                    m_out_cnt   = m_pend_cnt;
                    m_out_ovf   = m_pend_ovf;
                    m_closing   = 1'b0;
                end
            end else begin
                if (accept) m_win.push_back(int'(bus.din));
                if (m_win.size() == WIN || (bus.flush && m_win.size() > 0)) close_window();
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        repeat (n) cycle();
    endtask

    task automatic send(input int v, input bit fl);
        int guard;
        guard = 0;
        bus.in_valid = 1'b1;
        bus.din      = WIDTH'(v);
        bus.flush    = fl;
        do begin
            cycle();
            guard++;
        end while (!m_dut_accept && guard < 20);
        check("send_accepted", m_dut_accept, 1);
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
    endtask

    task automatic wait_out(input string name);
        int k;
        k = 0;
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        while (!bus.out_valid && k < 20) begin
            cycle();
            k++;
        end
        #1;
        check({name, "_seen"}, bus.out_valid, 1);
    endtask

    // Asserts reset between clock edges, checks the immediate clear, then releases.
    task automatic do_reset(input int hold);
        #2 rst = 1'b0;
        #1;
        check("arst_out_valid", bus.out_valid, 0);
        check("arst_in_ready", bus.in_ready, 0);
        check("arst_acc_clr", bus.acc_clr, 1);
        check("arst_out_data", bus.out_data, 0);
        check("arst_out_cnt", bus.out_cnt, 0);
        model_reset();
        @(negedge clk);
        repeat (hold) cycle();
        rst = 1'b1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.din       = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        model_reset();

        // Reset release: one INIT cycle clearing the accumulator.
        @(negedge clk);
        repeat (2) cycle();
        rst = 1'b1;
        #1;
        check("init_acc_clr", bus.acc_clr, 1);
        check("init_in_ready", bus.in_ready, 0);
        cycle();
        #1;
        check("post_init_in_ready", bus.in_ready, 1);
        check("post_init_acc_clr", bus.acc_clr, 0);

        // Full window 1,2,3,4.
        send(1, 0); send(2, 0); send(3, 0); send(4, 0);
        #1;
        check("full_dump_in_ready", bus.in_ready, 0);
        check("full_dump_acc_clr", bus.acc_clr, 1);
        check("full_dump_out_valid", bus.out_valid, 0);
        cycle();
        #1;
        check("full_out_valid_t2", bus.out_valid, 1);
        check("full_in_ready_t2", bus.in_ready, 1);
        check("full_data", bus.out_data, 10);
        check("full_cnt", bus.out_cnt, 4);
        check("full_ovf", bus.out_ovf, 0);
        idle(1);

        // Wrap, then a clean window.
        send(15, 0); send(15, 0); send(1, 0); send(0, 0);
        wait_out("wrap");
        check("wrap_data", bus.out_data, 15);
        check("wrap_cnt", bus.out_cnt, 4);
        check("wrap_ovf", bus.out_ovf, 1);
        idle(1);
        send(1, 0); send(1, 0); send(1, 0); send(1, 0);
        wait_out("clean");
        check("clean_data", bus.out_data, 4);
        check("clean_ovf", bus.out_ovf, 0);
        idle(1);

        // Flush with a sample in the same cycle, then an empty flush.
        send(5, 0); send(6, 1);
        wait_out("flush");
        check("flush_data", bus.out_data, 11);
        check("flush_cnt", bus.out_cnt, 2);
        check("flush_ovf", bus.out_ovf, 0);
        idle(1);
        bus.flush = 1'b1;
        cycle();
        idle(3);
        #1;
        check("empty_flush_no_out", bus.out_valid, 0);
        check("empty_flush_ready", bus.in_ready, 1);

        // Backpressure: one result pending while a second window completes.
        bus.out_ready = 1'b0;
        send(1, 0); send(1, 0); send(1, 0); send(1, 0);
        idle(2);
        send(2, 0); send(2, 0); send(2, 0); send(2, 0);
        idle(3);
        #1;
        check("bp_in_ready", bus.in_ready, 0);
        check("bp_acc_clr", bus.acc_clr, 0);
        check("bp_out_valid", bus.out_valid, 1);
        check("bp_first_data", bus.out_data, 4);
        bus.out_ready = 1'b1;
        #1;
        check("bp_release_acc_clr", bus.acc_clr, 1);
        cycle();
        bus.out_ready = 1'b0;
        #1;
        check("bp_second_valid", bus.out_valid, 1);
        check("bp_second_data", bus.out_data, 8);
        check("bp_second_cnt", bus.out_cnt, 4);
        bus.out_ready = 1'b1;
        idle(2);

        // Asynchronous reset mid-window.
        send(3, 0); send(3, 0);
        do_reset(2);
        send(2, 0); send(3, 0); send(4, 0); send(5, 0);
        wait_out("after_rst");
        check("after_rst_data", bus.out_data, 14);
        check("after_rst_cnt", bus.out_cnt, 4);
        check("after_rst_ovf", bus.out_ovf, 0);
        idle(2);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            bus.in_valid  = ($urandom_range(3) != 0);
            bus.din       = WIDTH'($urandom);
            bus.flush     = ($urandom_range(7) == 0);
            bus.out_ready = ($urandom_range(2) != 0);
            if (i == 1500) do_reset(1);
            else           cycle();
        end
        idle(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
